issue_hazard_ctrl: RTL and testbench
====================================

Name: issue_hazard_ctrl

Overview:
- Decode/issue controller for the 2-bit-opcode pipelined processor. Sits between the IF/ID register and the EX stage.
- Decodes each instruction into ALU_OP and Reg_Write and tracks in-flight register writes in a shift-register scoreboard.
- Stalls the front end, and inserts bubbles, while a read-after-write hazard exists. Optionally selects forwarding sources instead of stalling.

Parameters:
- INSTR_W, 8: instruction width. Must satisfy INSTR_W >= 2+2*REG_AW.
- REG_AW, 3: register address width.
- DEPTH, 2: number of tracked stages from EX to WB inclusive. Minimum 2.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock. Everything samples on the rising edge.
- reset  in  1  synchronous, active-high reset.
- In_Valid  in  1  fetch stage presents an instruction.
- In_Instr  in  INSTR_W  instruction fields: OpCode [INSTR_W-1:INSTR_W-2], Rd next REG_AW bits, Rs low REG_AW bits.
- In_Ready  out  1  combinational. Instruction accepted this cycle when In_Valid && In_Ready.
- Issue_Valid  out  1  registered. EX stage holds a valid instruction.
- Issue_Rd, Issue_Rs  out  REG_AW each  registered operand fields.
- Issue_ALU_OP  out  1  0 = add, 1 = logical shift left.
- Issue_Reg_Write  out  1  writeback required.
- Fwd_Sel_Rd, Fwd_Sel_Rs  out  clog2(DEPTH)+1 each  0 = register file; k = pipe slot k.
- Retire_Valid, Retire_Rd  out  1, REG_AW  writing instruction leaving slot DEPTH-1 this cycle.
- Stall_Count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset:
  - Issue_*, Fwd_Sel_*, Stall_Count and all slot valid bits go to 0. In_Ready = 0 while reset is high.
  - Reset mid-operation discards in-flight instructions. No Retire_Valid pulse is produced for them.
- Decode:
  - OpCode 00 (ADD): ALU_OP=0, Reg_Write=1, reads Rd and Rs.
  - OpCode 01 (SLL): ALU_OP=1, Reg_Write=1, reads Rd only. Rs is a shift amount.
  - OpCode 10/11: ALU_OP=0, Reg_Write=0, reads nothing.
- Pipe tracker:
  - Slot 0 is the Issue register (EX). Slots 1..DEPTH-1 shift every cycle unconditionally.
  - Each slot holds {valid, Reg_Write, Rd}.
  - Slot DEPTH-1 writes the register file at the end of its cycle; Retire_* is driven from it.
  - The register file has no internal bypass.
- Hazard:
  - A read register matches a valid slot with Reg_Write=1.
  - Without forwarding, any matching slot 0..DEPTH-1 is a hazard.
  - hazard -> In_Ready=0. The next cycle's slot 0 is a bubble (Issue_Valid=0).
  - Stall_Count increments on every cycle with In_Valid && hazard. It saturates at all ones and never wraps.
- Accept: In_Valid && In_Ready -> the next cycle has Issue_Valid=1 with the decoded fields. Latency is 1 cycle.
- In_Valid=0: In_Ready=1, a bubble is inserted, and Stall_Count is unchanged.
- Fetch must hold In_Instr stable while In_Valid && !In_Ready.
- Multiple matching slots: the youngest (lowest index) determines the hazard and the forward select.
- Back-to-back dependent, no forwarding: the consumer issues DEPTH+1 cycles after the producer, with DEPTH stall cycles.
- Opcodes 10/11 never mark a register busy and never stall.

Optional Feature:
- Macro: ISSUE_HAZARD_CTRL_FORWARD_EN.
- Defined:
  - Matches in slots 1..DEPTH-1 do not stall. Fwd_Sel for that operand = the youngest matching slot index, registered with the issue.
  - A slot 0 match still stalls exactly 1 cycle, then forwards from slot 1.
- Undefined:
  - Fwd_Sel_* is tied to 0 and stall rules are as in Behaviour.
  - Port list is identical in both builds.

Decomposition:
- Package issue_ctrl_pkg:
  - OP_ADD=2'b00, OP_SLL=2'b01.
  - Field-position constants.
  - FWD_RF=0 encoding.
  - Slot struct typedef {valid, wen, rd}.
- One sub-module, pipe_tracker: a DEPTH-slot shift register exposing per-slot fields to the hazard logic. Decode, hazard logic and counter live in the top.

Test Plan:
- Reset: assert reset 2 cycles mid-stream -> In_Ready=0 during reset. Next cycle: Issue_Valid=0, Stall_Count=0, Retire_Valid=0 for 3 cycles.
- Independent stream ADD r1,r2; ADD r3,r4; SLL r5,2 on consecutive cycles:
  - In_Ready stays 1.
  - Issue_Valid=1 for 3 cycles starting one cycle later.
  - ALU_OP sequence 0,0,1. Stall_Count=0.
- RAW, DEPTH=2, no macro: ADD r1,r2 then ADD r3,r1 -> In_Ready=0 for 2 cycles, consumer issues 3 cycles after producer, Stall_Count=2, Fwd_Sel_Rs=0.
- RAW with ISSUE_HAZARD_CTRL_FORWARD_EN, same stimulus -> 1 stall cycle, consumer issues with Fwd_Sel_Rs=1, Stall_Count=1.
- SLL r5 then SLL r5 -> stall (Rd read). OpCode 11 with Rd=r5 after ADD r5 -> no stall, Issue_Reg_Write=0, no later Retire_Valid for it.
- CNT_W=4, hold a hazard with In_Valid=1 for 20 cycles (DEPTH=20) -> Stall_Count saturates at 15.

Source files
------------

// File: rtl/issue_ctrl_pkg.sv
// issue_ctrl_pkg
// Shared definitions for the issue/hazard controller:
//   - opcode encodings and instruction field positions
//   - forward-select encoding for "read from register file"
//   - slot_t: one entry of the in-flight write tracker {valid, wen, rd}
//   - dec_t / decode_op(): opcode decode into ALU op, writeback and read-use
package issue_ctrl_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;

    // Opcode occupies the top OPC_W bits, Rs the lowest REG_AW bits and
    // Rd the REG_AW bits directly above Rs.
    localparam int OPC_W  = 2;
    localparam int RS_LSB = 0;

    // Forward select value meaning "operand comes from the register file".
    localparam int FWD_RF = 0;

    // Slot rd is stored at this fixed width; narrower register addresses
    // are zero-extended so comparisons stay full width.
    localparam int MAX_REG_AW = 8;

    typedef struct packed {
        logic                  valid;
        logic                  wen;
        logic [MAX_REG_AW-1:0] rd;
    } slot_t;

    typedef struct packed {
        logic alu_op;
        logic reg_write;
        logic reads_rd;
        logic reads_rs;
    } dec_t;

    // Opcode decode. SLL uses Rs as a shift amount, so only Rd is read.
    function automatic dec_t decode_op(input logic [OPC_W-1:0] opc);
        dec_t d;
        d = '0;
        case (opc)
            OP_ADD: begin
                d.alu_op    = 1'b0;
                d.reg_write = 1'b1;
                d.reads_rd  = 1'b1;
                d.reads_rs  = 1'b1;
            end
            OP_SLL: begin
                d.alu_op    = 1'b1;
                d.reg_write = 1'b1;
                d.reads_rd  = 1'b1;
                d.reads_rs  = 1'b0;
            end
            default: begin
                d = '0;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/issue_hazard_ctrl_pipe_tracker.sv
// pipe_tracker
// DEPTH-slot shift register of in-flight instructions, EX (slot 0) to WB
// (slot DEPTH-1). Slot 0 loads from the issue decision; slots 1..DEPTH-1
// shift every cycle unconditionally. Every slot is exposed flat so the
// hazard logic can compare against all of them in parallel.
// Ports:
//   clk, reset     clock, synchronous active-high reset (clears all slots)
//   in_valid/wen/rd next contents of slot 0
//   slot_valid_o   per-slot valid bits
//   slot_wen_o     per-slot register-write bits
//   slot_rd_o      per-slot rd, MAX_REG_AW bits each, slot k at [k*MAX_REG_AW +: MAX_REG_AW]
module pipe_tracker
    import issue_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic                        in_wen,
    input  logic [MAX_REG_AW-1:0]       in_rd,
    output logic [DEPTH-1:0]            slot_valid_o,
    output logic [DEPTH-1:0]            slot_wen_o,
    output logic [DEPTH*MAX_REG_AW-1:0] slot_rd_o
);

    slot_t slot_q [DEPTH];
    slot_t slot_d [DEPTH];

    // Next-state: load slot 0, shift the rest one stage toward writeback.
    always_comb begin
        slot_d[0].valid = in_valid;
        slot_d[0].wen   = in_wen;
        slot_d[0].rd    = in_rd;
        for (int k = 1; k < DEPTH; k++) begin
            slot_d[k] = slot_q[k-1];
        end
    end

    // Slot registers; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

    // Flatten slot contents for the hazard comparators.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            slot_valid_o[k]                           = slot_q[k].valid;
            slot_wen_o[k]                             = slot_q[k].wen;
            slot_rd_o[k*MAX_REG_AW +: MAX_REG_AW]     = slot_q[k].rd;
        end
    end

endmodule

// File: rtl/issue_hazard_ctrl.sv
// issue_hazard_ctrl
// Decode/issue controller between the IF/ID register and EX. Decodes the
// presented instruction, checks its read registers against in-flight
// writes held in pipe_tracker, and either issues it (1-cycle latency) or
// stalls the front end and inserts a bubble.
// Configuration macro: ISSUE_HAZARD_CTRL_FORWARD_EN
//   undefined: any matching in-flight write stalls; Fwd_Sel_* stay 0.
//   defined:   only a slot-0 match stalls; other matches issue with
//              Fwd_Sel_* = youngest matching slot index.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   In_Valid, In_Instr    fetch handshake and instruction {op, rd, rs}
//   In_Ready              combinational accept (0 while reset or hazard)
//   Issue_*               registered EX-stage instruction
//   Fwd_Sel_Rd/Rs         registered forward source, 0 = register file
//   Retire_Valid/Rd       write leaving the last tracked slot
//   Stall_Count           saturating count of stalled cycles
// Requires INSTR_W >= 2 + 2*REG_AW, DEPTH >= 2, REG_AW <= MAX_REG_AW.
module issue_hazard_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int INSTR_W = 8,
    parameter int REG_AW  = 3,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     In_Valid,
    input  logic [INSTR_W-1:0]       In_Instr,
    output logic                     In_Ready,
    output logic                     Issue_Valid,
    output logic [REG_AW-1:0]        Issue_Rd,
    output logic [REG_AW-1:0]        Issue_Rs,
    output logic                     Issue_ALU_OP,
    output logic                     Issue_Reg_Write,
    output logic [$clog2(DEPTH):0]   Fwd_Sel_Rd,
    output logic [$clog2(DEPTH):0]   Fwd_Sel_Rs,
    output logic                     Retire_Valid,
    output logic [REG_AW-1:0]        Retire_Rd,
    output logic [CNT_W-1:0]         Stall_Count
);

    localparam int SEL_W   = $clog2(DEPTH) + 1;
    localparam int RD_LSB  = RS_LSB + REG_AW;
    localparam int OPC_LSB = INSTR_W - OPC_W;

    logic [OPC_W-1:0]           opc_s;
    logic [REG_AW-1:0]          rd_s;
    logic [REG_AW-1:0]          rs_s;
    logic [MAX_REG_AW-1:0]      rd_ext_s;
    logic [MAX_REG_AW-1:0]      rs_ext_s;
    dec_t                       dec_s;

    logic [DEPTH-1:0]            slot_valid_s;
    logic [DEPTH-1:0]            slot_wen_s;
    logic [DEPTH*MAX_REG_AW-1:0] slot_rd_s;
    logic [DEPTH-1:0]            match_rd_s;
    logic [DEPTH-1:0]            match_rs_s;

    logic                       stall_rd_s;
    logic                       stall_rs_s;
    logic                       hazard_s;
    logic                       accept_s;
    logic [SEL_W-1:0]           fwd_rd_s;
    logic [SEL_W-1:0]           fwd_rs_s;

    logic [REG_AW-1:0]          issue_rs_d,  issue_rs_q;
    logic                       alu_op_d,    alu_op_q;
    logic [SEL_W-1:0]           fwd_rd_d,    fwd_rd_q;
    logic [SEL_W-1:0]           fwd_rs_d,    fwd_rs_q;
    logic [CNT_W-1:0]           stall_cnt_d, stall_cnt_q;

    assign opc_s = In_Instr[OPC_LSB +: OPC_W];
    assign rd_s  = In_Instr[RD_LSB +: REG_AW];
    assign rs_s  = In_Instr[RS_LSB +: REG_AW];
    assign dec_s = decode_op(opc_s);

    // Zero-extend operand addresses to the slot rd width.
    always_comb begin
        rd_ext_s             = '0;
        rs_ext_s             = '0;
        rd_ext_s[REG_AW-1:0] = rd_s;
        rs_ext_s[REG_AW-1:0] = rs_s;
    end

    // Per-slot match of each operand against pending register writes.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            match_rd_s[k] = slot_valid_s[k] & slot_wen_s[k]
                          & (slot_rd_s[k*MAX_REG_AW +: MAX_REG_AW] == rd_ext_s);
            match_rs_s[k] = slot_valid_s[k] & slot_wen_s[k]
                          & (slot_rd_s[k*MAX_REG_AW +: MAX_REG_AW] == rs_ext_s);
        end
    end

`ifdef ISSUE_HAZARD_CTRL_FORWARD_EN
    logic [SEL_W-1:0] idx_rd_s;
    logic [SEL_W-1:0] idx_rs_s;

    // Youngest (lowest-index) matching slot wins: scan oldest to youngest
    // so the last hit overwrites.
    always_comb begin
        idx_rd_s = '0;
        idx_rs_s = '0;
        for (int k = DEPTH-1; k >= 0; k--) begin
            idx_rd_s = match_rd_s[k] ? SEL_W'(k) : idx_rd_s;
            idx_rs_s = match_rs_s[k] ? SEL_W'(k) : idx_rs_s;
        end
    end

    // A producer still in EX has no result yet, so only a slot-0 match stalls.
    assign stall_rd_s = dec_s.reads_rd & match_rd_s[0];
    assign stall_rs_s = dec_s.reads_rs & match_rs_s[0];
    assign fwd_rd_s   = (dec_s.reads_rd & (|match_rd_s)) ? idx_rd_s : SEL_W'(FWD_RF);
    assign fwd_rs_s   = (dec_s.reads_rs & (|match_rs_s)) ? idx_rs_s : SEL_W'(FWD_RF);
`else
    // No bypass anywhere, including the register file: any pending write stalls.
    assign stall_rd_s = dec_s.reads_rd & (|match_rd_s);
    assign stall_rs_s = dec_s.reads_rs & (|match_rs_s);
    assign fwd_rd_s   = SEL_W'(FWD_RF);
    assign fwd_rs_s   = SEL_W'(FWD_RF);
`endif

    assign hazard_s = stall_rd_s | stall_rs_s;
    assign In_Ready = ~reset & ~(In_Valid & hazard_s);
    assign accept_s = In_Valid & In_Ready;

    pipe_tracker #(
        .DEPTH (DEPTH)
    ) u_tracker (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (accept_s),
        .in_wen       (accept_s & dec_s.reg_write),
        .in_rd        (accept_s ? rd_ext_s : '0),
        .slot_valid_o (slot_valid_s),
        .slot_wen_o   (slot_wen_s),
        .slot_rd_o    (slot_rd_s)
    );

    // Issue-side fields not held in the tracker; bubbles carry zeros.
    always_comb begin
        if (accept_s) begin
            issue_rs_d = rs_s;
            alu_op_d   = dec_s.alu_op;
            fwd_rd_d   = fwd_rd_s;
            fwd_rs_d   = fwd_rs_s;
        end else begin
            issue_rs_d = '0;
            alu_op_d   = 1'b0;
            fwd_rd_d   = SEL_W'(FWD_RF);
            fwd_rs_d   = SEL_W'(FWD_RF);
        end
    end

    // Stall counter: count only real stalls, hold at all ones.
    always_comb begin
        if (In_Valid && hazard_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Issue and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_rs_q  <= '0;
            alu_op_q    <= 1'b0;
            fwd_rd_q    <= '0;
            fwd_rs_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_rs_q  <= issue_rs_d;
            alu_op_q    <= alu_op_d;
            fwd_rd_q    <= fwd_rd_d;
            fwd_rs_q    <= fwd_rs_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Slot 0 of the tracker is the EX register; the last slot retires.
    assign Issue_Valid     = slot_valid_s[0];
    assign Issue_Reg_Write = slot_wen_s[0];
    assign Issue_Rd        = slot_rd_s[0 +: REG_AW];
    assign Issue_Rs        = issue_rs_q;
    assign Issue_ALU_OP    = alu_op_q;
    assign Fwd_Sel_Rd      = fwd_rd_q;
    assign Fwd_Sel_Rs      = fwd_rs_q;
    assign Retire_Valid    = slot_valid_s[DEPTH-1] & slot_wen_s[DEPTH-1];
    assign Retire_Rd       = slot_rd_s[(DEPTH-1)*MAX_REG_AW +: REG_AW];
    assign Stall_Count     = stall_cnt_q;

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Testbench for issue_hazard_ctrl: directed scenarios plus a random stream,
// checked against an in-flight-write model kept as a list of {rd, wen, age}.
module tb_issue_hazard_ctrl;

    localparam int DEPTH = 2;
`ifdef ISSUE_HAZARD_CTRL_FORWARD_EN
    localparam int FWD = 1;
`else
    localparam int FWD = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (default parameters)
    logic       rst, in_valid, in_ready;
    logic [7:0] in_instr;
    logic       issue_valid, issue_alu_op, issue_reg_write, retire_valid;
    logic [2:0] issue_rd, issue_rs, retire_rd;
    logic [1:0] fwd_sel_rd, fwd_sel_rs;
    logic [15:0] stall_count;

    // Saturation instance (DEPTH=20, CNT_W=4)
    logic       s_rst, s_valid, s_ready;
    logic [7:0] s_instr;
    logic       s_iv, s_alu, s_wen, s_rv;
    logic [2:0] s_ird, s_irs, s_rrd;
    logic [5:0] s_frd, s_frs;
    logic [3:0] s_cnt;

    issue_hazard_ctrl u_dut (
        .clk(clk), .reset(rst), .In_Valid(in_valid), .In_Instr(in_instr),
        .In_Ready(in_ready), .Issue_Valid(issue_valid), .Issue_Rd(issue_rd),
        .Issue_Rs(issue_rs), .Issue_ALU_OP(issue_alu_op),
        .Issue_Reg_Write(issue_reg_write), .Fwd_Sel_Rd(fwd_sel_rd),
        .Fwd_Sel_Rs(fwd_sel_rs), .Retire_Valid(retire_valid),
        .Retire_Rd(retire_rd), .Stall_Count(stall_count)
    );

    issue_hazard_ctrl #(.INSTR_W(8), .REG_AW(3), .DEPTH(20), .CNT_W(4)) u_sat (
        .clk(clk), .reset(s_rst), .In_Valid(s_valid), .In_Instr(s_instr),
        .In_Ready(s_ready), .Issue_Valid(s_iv), .Issue_Rd(s_ird),
        .Issue_Rs(s_irs), .Issue_ALU_OP(s_alu), .Issue_Reg_Write(s_wen),
        .Fwd_Sel_Rd(s_frd), .Fwd_Sel_Rs(s_frs), .Retire_Valid(s_rv),
        .Retire_Rd(s_rrd), .Stall_Count(s_cnt)
    );

    // Reference model: instructions in flight, age 0 = in EX.
    typedef struct { int rd; bit wen; int age; } flight_t;
    flight_t fl[$];
    bit  m_iv;
    int  m_rd, m_rs, m_alu, m_wen, m_frd, m_frs, m_cnt;
    bit  last_acc;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  t;
    bit  r_v, r_hold;
    logic [7:0] r_ins;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Age of the youngest pending write to register r, -1 if none.
    function automatic int youngest(input int r);
        int best = -1;
        foreach (fl[i]) begin
            if (fl[i].wen && fl[i].rd == r && (best < 0 || fl[i].age < best)) best = fl[i].age;
        end
        return best;
    endfunction

    // One clock cycle: drive at negedge, check, advance model at posedge.
    task automatic step(input bit r, input bit v, input logic [7:0] ins);
        int opc, rd, rs, yd, ys, frd, frs, rrd;
        bit nd, ns, haz, acc, rv;
        flight_t nf[$];
        rst = r; in_valid = v; in_instr = ins;
        #1;
        opc = int'(ins[7:6]); rd = int'(ins[5:3]); rs = int'(ins[2:0]);
        nd = (opc <= 1); ns = (opc == 0);
        yd = nd ? youngest(rd) : -1;
        ys = ns ? youngest(rs) : -1;
        if (FWD != 0) begin
            haz = (yd == 0) || (ys == 0);
            frd = (yd > 0) ? yd : 0;
            frs = (ys > 0) ? ys : 0;
        end else begin
            haz = (yd >= 0) || (ys >= 0);
            frd = 0;
            frs = 0;
        end
        acc = !r && v && !haz;
        chk("in_ready", 32'(in_ready), 32'(!r && !(v && haz)));
        chk("issue_valid", 32'(issue_valid), 32'(m_iv));
        if (m_iv) begin
            chk("issue_rd", 32'(issue_rd), 32'(m_rd));
            chk("issue_rs", 32'(issue_rs), 32'(m_rs));
            chk("issue_alu_op", 32'(issue_alu_op), 32'(m_alu));
            chk("issue_reg_write", 32'(issue_reg_write), 32'(m_wen));
            chk("fwd_sel_rd", 32'(fwd_sel_rd), 32'(m_frd));
            chk("fwd_sel_rs", 32'(fwd_sel_rs), 32'(m_frs));
        end
        rv = 1'b0; rrd = 0;
        foreach (fl[i]) begin
            if (fl[i].age == DEPTH-1 && fl[i].wen) begin rv = 1'b1; rrd = fl[i].rd; end
        end
        chk("retire_valid", 32'(retire_valid), 32'(rv));
        if (rv) chk("retire_rd", 32'(retire_rd), 32'(rrd));
        chk("stall_count", 32'(stall_count), 32'(m_cnt));
        @(posedge clk);
        if (r) begin
            fl.delete(); m_iv = 1'b0; m_cnt = 0;
        end else begin
            nf = {};
            foreach (fl[i]) begin
                if (fl[i].age + 1 < DEPTH) nf.push_back('{rd: fl[i].rd, wen: fl[i].wen, age: fl[i].age + 1});
            end
            fl = nf;
            if (acc) begin
                fl.push_back('{rd: rd, wen: (opc <= 1), age: 0});
                m_iv = 1'b1; m_rd = rd; m_rs = rs; m_alu = (opc == 1) ? 1 : 0;
                m_wen = (opc <= 1) ? 1 : 0; m_frd = frd; m_frs = frs;
            end else begin
                m_iv = 1'b0;
            end
            if (v && haz && m_cnt < 65535) m_cnt++;
        end
        last_acc = acc;
        @(negedge clk);
    endtask

    // Present an instruction until the model says it is accepted (bounded).
    task automatic issue(input logic [7:0] ins, output int tries);
        tries = 0;
        do begin
            step(1'b0, 1'b1, ins);
            tries++;
        end while (!last_acc && tries < 50);
        chk("issue_accepted", 32'(last_acc), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = 8'd0;
        s_rst = 1'b1; s_valid = 1'b0; s_instr = 8'd0;
        fl = {}; m_iv = 1'b0; m_cnt = 0; last_acc = 1'b0;
        m_rd = 0; m_rs = 0; m_alu = 0; m_wen = 0; m_frd = 0; m_frs = 0;
        r_hold = 1'b0; r_v = 1'b0; r_ins = 8'd0;
        @(negedge clk);

        // Reset state
        step(1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b0, 8'd0);

        // Independent stream: ADD r1,r2; ADD r3,r4; SLL r5,2
        issue(8'b00_001_010, t); chk("indep0_tries", 32'(t), 32'd1);
        issue(8'b00_011_100, t); chk("indep1_tries", 32'(t), 32'd1);
        issue(8'b01_101_010, t); chk("indep2_tries", 32'(t), 32'd1);
        chk("indep_alu_sll", 32'(issue_alu_op), 32'd1);
        repeat (3) step(1'b0, 1'b0, 8'd0);
        chk("indep_stall_count", 32'(stall_count), 32'd0);

        // RAW: ADD r1,r2 then ADD r3,r1
        step(1'b1, 1'b0, 8'd0);
        issue(8'b00_001_010, t); chk("raw_prod_tries", 32'(t), 32'd1);
        issue(8'b00_011_001, t); chk("raw_cons_tries", 32'(t), 32'((FWD != 0) ? 2 : 3));
        chk("raw_fwd_rs", 32'(fwd_sel_rs), 32'((FWD != 0) ? 1 : 0));
        chk("raw_stall_count", 32'(stall_count), 32'((FWD != 0) ? 1 : 2));
        repeat (3) step(1'b0, 1'b0, 8'd0);

        // SLL r5 then SLL r5 (Rd read), then ADD r5 followed by opcode 11
        step(1'b1, 1'b0, 8'd0);
        issue(8'b01_101_001, t);
        issue(8'b01_101_010, t); chk("sll_tries", 32'(t), 32'((FWD != 0) ? 2 : 3));
        repeat (3) step(1'b0, 1'b0, 8'd0);
        issue(8'b00_101_000, t);
        issue(8'b11_101_000, t); chk("op3_tries", 32'(t), 32'd1);
        chk("op3_reg_write", 32'(issue_reg_write), 32'd0);
        repeat (4) step(1'b0, 1'b0, 8'd0);
        chk("op3_stall_count", 32'(stall_count), 32'((FWD != 0) ? 1 : 2));

        // Mid-stream reset with a stall pending, then 3 idle cycles
        step(1'b0, 1'b1, 8'b00_001_010);
        step(1'b0, 1'b1, 8'b00_010_001);
        step(1'b1, 1'b1, 8'b00_010_001);
        step(1'b1, 1'b1, 8'b00_010_001);
        repeat (3) step(1'b0, 1'b0, 8'd0);
        chk("post_reset_cnt", 32'(stall_count), 32'd0);

        // Random stream, registers 0..3 to provoke hazards, rare resets
        for (int i = 0; i < 600; i++) begin
            if (!r_hold) begin
                r_v   = ($urandom_range(3, 0) != 0);
                r_ins = {2'($urandom), 1'b0, 2'($urandom), 1'b0, 2'($urandom)};
            end
            step(($urandom_range(99, 0) == 0), r_v, r_ins);
            r_hold = r_v && !last_acc;
        end

        // Saturation: ADD r1,r1 held valid on DEPTH=20, CNT_W=4 instance
        s_valid = 1'b1; s_instr = 8'b00_001_001;
        #1;
        chk("sat_ready_in_reset", 32'(s_ready), 32'd0);
        @(negedge clk);
        s_rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("sat_count_10", 32'(s_cnt), 32'((FWD != 0) ? 5 : 9));
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("sat_count_40", 32'(s_cnt), 32'd15);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("sat_count_hold", 32'(s_cnt), 32'd15);
        s_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
